// File: rtl/axi_chk_pkg.sv
// Shared constants for the passive AXI4 protocol checker.
package axi_chk_pkg;

    localparam int unsigned NUM_ERR = 16;
    localparam int unsigned NUM_CH  = 5;
    localparam int unsigned AXLEN_W = 8;

    // Channel indices used by the per-channel stability/timeout slices
    localparam int unsigned CH_AW = 0;
    localparam int unsigned CH_W  = 1;
    localparam int unsigned CH_B  = 2;
    localparam int unsigned CH_AR = 3;
    localparam int unsigned CH_R  = 4;

    // Error bit positions in err_flags / err_pulse
    localparam int unsigned ERR_AW_STABLE  = 0;
    localparam int unsigned ERR_W_STABLE   = 1;
    localparam int unsigned ERR_B_STABLE   = 2;
    localparam int unsigned ERR_AR_STABLE  = 3;
    localparam int unsigned ERR_R_STABLE   = 4;
    localparam int unsigned ERR_AW_TIMEOUT = 5;
    localparam int unsigned ERR_W_TIMEOUT  = 6;
    localparam int unsigned ERR_B_TIMEOUT  = 7;
    localparam int unsigned ERR_AR_TIMEOUT = 8;
    localparam int unsigned ERR_R_TIMEOUT  = 9;
    localparam int unsigned ERR_WLAST      = 10;
    localparam int unsigned ERR_RLAST      = 11;
    localparam int unsigned ERR_B_NO_WR    = 12;
    localparam int unsigned ERR_R_NO_RD    = 13;
    localparam int unsigned ERR_ADDR_OVF   = 14;
    localparam int unsigned ERR_W_NO_AW    = 15;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/axi_chk_burst_tracker.sv
// Burst length FIFO, beat counter, LAST check and outstanding counter for one direction.
module axi_chk_burst_tracker
    import axi_chk_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned OUT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [AXLEN_W-1:0] push_len,
    input  logic               beat,
    input  logic               last,
    input  logic               retire,
    output logic [OUT_W-1:0]   outstanding,
    output logic               last_err_c,
    output logic               empty_err_c,
    output logic               ovf_err_c,
    output logic               retire_err_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [AXLEN_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OUT_W-1:0]   fill;
    logic [AXLEN_W:0]   beats;
    logic               empty_c;
    logic               full_c;
    logic               pop_c;
    logic               push_ok_c;
    logic               dec_c;

    assign empty_c   = (fill == '0);
    assign full_c    = (fill == OUT_W'(DEPTH));
    assign pop_c     = beat && last && !empty_c;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign push_ok_c = push && (!full_c || pop_c);
    assign dec_c     = retire && (outstanding != '0);

    assign last_err_c   = beat && !empty_c && (last != (beats == {1'b0, mem[rd_ptr]}));
    assign empty_err_c  = beat && empty_c;
    assign ovf_err_c    = push && full_c && !pop_c;
    assign retire_err_c = retire && (outstanding == '0);

    // FIFO storage, pointers, beat counter and outstanding count
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            beats       <= '0;
            outstanding <= '0;
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= push_len;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok_c, pop_c})
                2'b10:   fill <= fill + OUT_W'(1);
                2'b01:   fill <= fill - OUT_W'(1);
                default: fill <= fill;
            endcase
            if (beat && !empty_c) begin
                beats <= last ? '0 : beats + (AXLEN_W+1)'(1);
            end
            case ({push_ok_c, dec_c})
                2'b10:   outstanding <= (outstanding == '1) ? outstanding : outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: rtl/axi_protocol_checker.sv
// Passive AXI4 protocol checker: handshake stability, timeouts and burst bookkeeping.
module axi_protocol_checker
    import axi_chk_pkg::*;
#(
    parameter  int unsigned ID_W        = 8,
    parameter  int unsigned ADDR_W      = 32,
    parameter  int unsigned DATA_W      = 32,
    parameter  int unsigned MAX_WAIT    = 16,
    parameter  int unsigned OUTST_DEPTH = 8,
    localparam int unsigned OUT_W       = $clog2(OUTST_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_err,
    input  logic [ID_W-1:0]      AWID,
    input  logic [ADDR_W-1:0]    AWADDR,
    input  logic [AXLEN_W-1:0]   AWLEN,
    input  logic [2:0]           AWSIZE,
    input  logic [1:0]           AWBURST,
    input  logic                 AWVALID,
    input  logic                 AWREADY,
    input  logic [DATA_W-1:0]    WDATA,
    input  logic [DATA_W/8-1:0]  WSTRB,
    input  logic                 WLAST,
    input  logic                 WVALID,
    input  logic                 WREADY,
    input  logic [ID_W-1:0]      BID,
    input  logic [1:0]           BRESP,
    input  logic                 BVALID,
    input  logic                 BREADY,
    input  logic [ID_W-1:0]      ARID,
    input  logic [ADDR_W-1:0]    ARADDR,
    input  logic [AXLEN_W-1:0]   ARLEN,
    input  logic [2:0]           ARSIZE,
    input  logic [1:0]           ARBURST,
    input  logic                 ARVALID,
    input  logic                 ARREADY,
    input  logic [ID_W-1:0]      RID,
    input  logic [DATA_W-1:0]    RDATA,
    input  logic [1:0]           RRESP,
    input  logic                 RLAST,
    input  logic                 RVALID,
    input  logic                 RREADY,
    output logic [NUM_ERR-1:0]   err_flags,
    output logic [NUM_ERR-1:0]   err_pulse,
    output logic [OUT_W-1:0]     wr_outstanding,
    output logic [OUT_W-1:0]     rd_outstanding
);

    localparam int unsigned AX_PAY_W = ID_W + ADDR_W + AXLEN_W + 3 + 2;
    localparam int unsigned W_PAY_W  = DATA_W + DATA_W / 8 + 1;
    localparam int unsigned R_PAY_W  = ID_W + DATA_W + 2 + 1;
    localparam int unsigned PAY_W    = max3(AX_PAY_W, W_PAY_W, R_PAY_W);
    // Wide enough to hold MAX_WAIT, and at least one bit when timeouts are disabled
    localparam int unsigned TO_W     = $clog2(MAX_WAIT + 2);

    logic [NUM_CH-1:0]  ch_valid;
    logic [NUM_CH-1:0]  ch_ready;
    logic [PAY_W-1:0]   ch_pay [NUM_CH];
    logic [NUM_CH-1:0]  stab_err_c;
    logic [NUM_CH-1:0]  to_err_c;
    logic [NUM_ERR-1:0] new_err_c;

    logic wr_last_err_c, wr_empty_err_c, wr_ovf_err_c, wr_retire_err_c;
    logic rd_last_err_c, rd_empty_err_c, rd_ovf_err_c, rd_retire_err_c;

    assign ch_valid = {RVALID, ARVALID, BVALID, WVALID, AWVALID};
    assign ch_ready = {RREADY, ARREADY, BREADY, WREADY, AWREADY};

    assign ch_pay[CH_AW] = PAY_W'({AWID, AWADDR, AWLEN, AWSIZE, AWBURST});
    assign ch_pay[CH_W]  = PAY_W'({WDATA, WSTRB, WLAST});
    assign ch_pay[CH_B]  = PAY_W'({BID, BRESP});
    assign ch_pay[CH_AR] = PAY_W'({ARID, ARADDR, ARLEN, ARSIZE, ARBURST});
    assign ch_pay[CH_R]  = PAY_W'({RID, RDATA, RRESP, RLAST});

    for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch
        logic             stalled_c;
        logic             stall_q;
        logic [PAY_W-1:0] pay_q;
        logic [TO_W-1:0]  wait_q;

        assign stalled_c     = ch_valid[c] && !ch_ready[c];
        assign stab_err_c[c] = stall_q && (!ch_valid[c] || (ch_pay[c] != pay_q));
        assign to_err_c[c]   = (MAX_WAIT != 0) && stalled_c && (wait_q == TO_W'(MAX_WAIT - 1));

        // Remember last stall/payload and count consecutive stalled edges (saturating)
        always_ff @(posedge clk) begin
            if (reset) begin
                stall_q <= 1'b0;
                pay_q   <= '0;
                wait_q  <= '0;
            end else begin
                stall_q <= stalled_c;
                pay_q   <= ch_pay[c];
                if (!stalled_c) begin
                    wait_q <= '0;
                end else if (wait_q != TO_W'(MAX_WAIT)) begin
                    wait_q <= wait_q + TO_W'(1);
                end
            end
        end
    end

    axi_chk_burst_tracker #(.DEPTH(OUTST_DEPTH)) u_wr_trk (
        .clk          (clk),
        .reset        (reset),
        .push         (AWVALID && AWREADY),
        .push_len     (AWLEN),
        .beat         (WVALID && WREADY),
        .last         (WLAST),
        .retire       (BVALID && BREADY),
        .outstanding  (wr_outstanding),
        .last_err_c   (wr_last_err_c),
        .empty_err_c  (wr_empty_err_c),
        .ovf_err_c    (wr_ovf_err_c),
        .retire_err_c (wr_retire_err_c)
    );

    // Reads retire on the final beat, so the data channel doubles as the response
    axi_chk_burst_tracker #(.DEPTH(OUTST_DEPTH)) u_rd_trk (
        .clk          (clk),
        .reset        (reset),
        .push         (ARVALID && ARREADY),
        .push_len     (ARLEN),
        .beat         (RVALID && RREADY),
        .last         (RLAST),
        .retire       (RVALID && RREADY && RLAST),
        .outstanding  (rd_outstanding),
        .last_err_c   (rd_last_err_c),
        .empty_err_c  (rd_empty_err_c),
        .ovf_err_c    (rd_ovf_err_c),
        .retire_err_c (rd_retire_err_c)
    );

    // Gather this cycle's violations into the error vector
    always_comb begin
        new_err_c                           = '0;
        new_err_c[ERR_AW_STABLE +: NUM_CH]  = stab_err_c;
        new_err_c[ERR_AW_TIMEOUT +: NUM_CH] = to_err_c;
        new_err_c[ERR_WLAST]                = wr_last_err_c;
        new_err_c[ERR_RLAST]                = rd_last_err_c;
        new_err_c[ERR_B_NO_WR]              = wr_retire_err_c;
        new_err_c[ERR_R_NO_RD]              = rd_empty_err_c || rd_retire_err_c;
        new_err_c[ERR_ADDR_OVF]             = wr_ovf_err_c || rd_ovf_err_c;
        new_err_c[ERR_W_NO_AW]              = wr_empty_err_c;
    end

    // Register pulses; sticky flags clear on clr_err but still capture same-cycle errors
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flags <= '0;
            err_pulse <= '0;
        end else begin
            err_pulse <= new_err_c;
            err_flags <= (clr_err ? '0 : err_flags) | new_err_c;
        end
    end

endmodule

// File: tb/tb_axi_protocol_checker.sv
// Randomized and directed bench for axi_protocol_checker with a queue-based reference model.
module tb_axi_protocol_checker;
    import axi_chk_pkg::*;

    localparam int ID_W = 8, ADDR_W = 32, DATA_W = 32, MAX_WAIT = 16, DEPTH = 8;
    localparam int OUT_W = $clog2(DEPTH) + 1;
    localparam int OUT_MAX = (1 << OUT_W) - 1;

    logic clk, reset, clr_err;
    logic [ID_W-1:0] AWID, BID, ARID, RID;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic [7:0] AWLEN, ARLEN;
    logic [2:0] AWSIZE, ARSIZE;
    logic [1:0] AWBURST, ARBURST, BRESP, RRESP;
    logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [DATA_W-1:0] WDATA, RDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic [15:0] err_flags, err_pulse;
    logic [OUT_W-1:0] wr_outstanding, rd_outstanding;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int wq[$];
    int rq[$];
    int wbeats, rbeats, wout, rout;
    int scnt[5];
    bit prev_stall[5];
    logic [127:0] prev_pay[5];
    logic [15:0] m_flags, m_pulse;

    axi_protocol_checker #(
        .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MAX_WAIT(MAX_WAIT), .OUTST_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .clr_err(clr_err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .err_flags(err_flags), .err_pulse(err_pulse),
        .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit vld(int c);
        case (c)
            0: return AWVALID;
            1: return WVALID;
            2: return BVALID;
            3: return ARVALID;
            default: return RVALID;
        endcase
    endfunction

    function automatic bit rdy(int c);
        case (c)
            0: return AWREADY;
            1: return WREADY;
            2: return BREADY;
            3: return ARREADY;
            default: return RREADY;
        endcase
    endfunction

    function automatic logic [127:0] pay(int c);
        case (c)
            0: return 128'({AWID, AWADDR, AWLEN, AWSIZE, AWBURST});
            1: return 128'({WDATA, WSTRB, WLAST});
            2: return 128'({BID, BRESP});
            3: return 128'({ARID, ARADDR, ARLEN, ARSIZE, ARBURST});
            default: return 128'({RID, RDATA, RRESP, RLAST});
        endcase
    endfunction

    // Apply the checker rules to the inputs sampled at this clock edge
    task automatic model_step();
        logic [15:0] e;
        bit st, full_pre, popped;
        int inc, dec;
        if (reset) begin
            wq.delete(); rq.delete();
            wbeats = 0; rbeats = 0; wout = 0; rout = 0;
            m_flags = '0; m_pulse = '0;
            for (int c = 0; c < 5; c++) begin
                prev_stall[c] = 0; scnt[c] = 0; prev_pay[c] = '0;
            end
            return;
        end
        e = '0;
        for (int c = 0; c < 5; c++) begin
            st = vld(c) && !rdy(c);
            if (prev_stall[c] && (!vld(c) || pay(c) != prev_pay[c])) e[ERR_AW_STABLE + c] = 1'b1;
            if (st) begin
                scnt[c]++;
                if (MAX_WAIT != 0 && scnt[c] == MAX_WAIT) e[ERR_AW_TIMEOUT + c] = 1'b1;
            end else begin
                scnt[c] = 0;
            end
            prev_stall[c] = st;
            prev_pay[c] = pay(c);
        end
        // write direction
        full_pre = (wq.size() == DEPTH);
        popped = 0;
        if (WVALID && WREADY) begin
            if (wq.size() == 0) e[ERR_W_NO_AW] = 1'b1;
            else begin
                wbeats++;
                if (WLAST != (wbeats == wq[0] + 1)) e[ERR_WLAST] = 1'b1;
                if (WLAST) begin
                    void'(wq.pop_front());
                    wbeats = 0;
                    popped = 1;
                end
            end
        end
        inc = 0;
        if (AWVALID && AWREADY) begin
            if (full_pre && !popped) e[ERR_ADDR_OVF] = 1'b1;
            else begin wq.push_back(int'(AWLEN)); inc = 1; end
        end
        dec = 0;
        if (BVALID && BREADY) begin
            if (wout == 0) e[ERR_B_NO_WR] = 1'b1;
            else dec = 1;
        end
        wout = wout + inc - dec;
        if (wout > OUT_MAX) wout = OUT_MAX;
        // read direction
        full_pre = (rq.size() == DEPTH);
        popped = 0;
        dec = 0;
        if (RVALID && RREADY) begin
            if (rq.size() == 0) e[ERR_R_NO_RD] = 1'b1;
            else begin
                rbeats++;
                if (RLAST != (rbeats == rq[0] + 1)) e[ERR_RLAST] = 1'b1;
                if (RLAST) begin
                    void'(rq.pop_front());
                    rbeats = 0;
                    popped = 1;
                    dec = 1;
                end
            end
        end
        inc = 0;
        if (ARVALID && ARREADY) begin
            if (full_pre && !popped) e[ERR_ADDR_OVF] = 1'b1;
            else begin rq.push_back(int'(ARLEN)); inc = 1; end
        end
        rout = rout + inc - dec;
        if (rout > OUT_MAX) rout = OUT_MAX;
        m_pulse = e;
        m_flags = (clr_err ? 16'h0 : m_flags) | e;
    endtask

    // One clock: model follows the edge, DUT sampled 1 ns later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("err_flags", 32'(err_flags), 32'(m_flags));
        chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("wr_outstanding", 32'(wr_outstanding), 32'(wout));
        chk("rd_outstanding", 32'(rd_outstanding), 32'(rout));
    endtask

    task automatic idle();
        AWVALID = 0; AWREADY = 0; WVALID = 0; WREADY = 0; BVALID = 0; BREADY = 0;
        ARVALID = 0; ARREADY = 0; RVALID = 0; RREADY = 0; WLAST = 0; RLAST = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1; tick(); tick();
        reset = 0;
    endtask

    task automatic aw_hs(input int len);
        AWVALID = 1; AWREADY = 1; AWLEN = 8'(len); AWID = 8'($urandom_range(255));
        AWADDR = 32'($urandom) & 32'hFFFF_FFFC;
        tick();
        AWVALID = 0; AWREADY = 0;
    endtask

    task automatic ar_hs(input int len);
        ARVALID = 1; ARREADY = 1; ARLEN = 8'(len); ARADDR = 32'($urandom) & 32'hFFFF_FFFC;
        tick();
        ARVALID = 0; ARREADY = 0;
    endtask

    task automatic w_beat(input bit last);
        WVALID = 1; WREADY = 1; WLAST = last; WDATA = $urandom; WSTRB = 4'hF;
        tick();
        WVALID = 0; WREADY = 0; WLAST = 0;
    endtask

    task automatic r_beat(input bit last);
        RVALID = 1; RREADY = 1; RLAST = last; RDATA = $urandom;
        tick();
        RVALID = 0; RREADY = 0; RLAST = 0;
    endtask

    task automatic b_hs();
        BVALID = 1; BREADY = 1; BRESP = RESP_OKAY;
        tick();
        BVALID = 0; BREADY = 0;
    endtask

    // Mostly-compliant random master/slave: stalled channels usually hold their payload
    task automatic rand_inputs(input int blk);
        if (!(AWVALID && !AWREADY && $urandom_range(7) != 0)) begin
            AWVALID = ($urandom_range(3) == 0); AWID = 8'($urandom_range(3));
            AWADDR = 32'($urandom_range(15)) << 2; AWLEN = 8'($urandom_range(3));
        end
        if (!(WVALID && !WREADY && $urandom_range(7) != 0)) begin
            WVALID = ($urandom_range(1) == 0); WDATA = 32'($urandom_range(3));
            WLAST = ($urandom_range(4) < 2); WSTRB = 4'hF;
        end
        if (!(BVALID && !BREADY && $urandom_range(7) != 0)) begin
            BVALID = ($urandom_range(3) == 0); BID = 8'($urandom_range(3)); BRESP = 2'($urandom_range(3));
        end
        if (!(ARVALID && !ARREADY && $urandom_range(7) != 0)) begin
            ARVALID = ($urandom_range(3) == 0); ARID = 8'($urandom_range(3));
            ARADDR = 32'($urandom_range(15)) << 2; ARLEN = 8'($urandom_range(3));
        end
        if (!(RVALID && !RREADY && $urandom_range(7) != 0)) begin
            RVALID = ($urandom_range(1) == 0); RDATA = 32'($urandom_range(3));
            RLAST = ($urandom_range(4) < 2); RID = 8'($urandom_range(3)); RRESP = 2'($urandom_range(3));
        end
        AWREADY = (blk == 0) ? 1'b0 : 1'($urandom_range(1));
        WREADY  = (blk == 1) ? 1'b0 : 1'($urandom_range(1));
        BREADY  = (blk == 2) ? 1'b0 : 1'($urandom_range(1));
        ARREADY = (blk == 3) ? 1'b0 : 1'($urandom_range(1));
        RREADY  = (blk == 4) ? 1'b0 : 1'($urandom_range(1));
    endtask

    initial begin
        int npulse, at;
        int blk;
        clr_err = 0; reset = 1;
        AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 3'd2; AWBURST = BURST_INCR;
        WDATA = 0; WSTRB = 4'hF; BID = 0; BRESP = RESP_OKAY;
        ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 3'd2; ARBURST = BURST_INCR;
        RID = 0; RDATA = 0; RRESP = RESP_OKAY;
        do_reset();
        tick();
        chk("reset_flags", 32'(err_flags), 32'h0);
        chk("reset_wr_out", 32'(wr_outstanding), 32'h0);

        // Clean 4-beat write
        aw_hs(3);
        chk("wr_out_after_aw", 32'(wr_outstanding), 32'd1);
        for (int i = 0; i < 4; i++) w_beat(i == 3);
        b_hs();
        chk("clean_wr_out", 32'(wr_outstanding), 32'd0);
        chk("clean_wr_flags", 32'(err_flags), 32'h0);

        // AR payload changes while stalled
        ARVALID = 1; ARREADY = 0; ARADDR = 32'h100; ARLEN = 0;
        tick();
        ARADDR = 32'h104;
        tick();
        chk("ar_stab_pulse", 32'(err_pulse), 32'h0008);
        ARREADY = 1;
        tick();
        chk("ar_stab_pulse_gone", 32'(err_pulse), 32'h0);
        chk("ar_stab_flag", 32'(err_flags), 32'h0008);
        idle();
        r_beat(1);
        chk("ar_rd_out", 32'(rd_outstanding), 32'd0);
        clr_err = 1; tick(); clr_err = 0;
        chk("clr_flags", 32'(err_flags), 32'h0);

        // W stalled for 20 cycles
        aw_hs(0);
        WVALID = 1; WREADY = 0; WLAST = 1; WDATA = 32'hCAFE;
        npulse = 0; at = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (err_pulse[ERR_W_TIMEOUT]) begin npulse++; at = k; end
        end
        chk("w_to_count", 32'(npulse), 32'd1);
        chk("w_to_cycle", 32'(at), 32'd16);
        WREADY = 1; tick(); idle();
        b_hs();
        chk("w_to_flags", 32'(err_flags), 32'h0040);
        clr_err = 1; tick(); clr_err = 0;

        // Early RLAST, then a clean single-beat read
        ar_hs(1);
        r_beat(1);
        chk("rlast_pulse", 32'(err_pulse), 32'h0800);
        ar_hs(0);
        r_beat(1);
        chk("rlast_clean_pulse", 32'(err_pulse), 32'h0);
        chk("rlast_rd_out", 32'(rd_outstanding), 32'd0);
        clr_err = 1; tick(); clr_err = 0;

        // Overflow on the ninth AW, then B with nothing outstanding
        for (int i = 0; i < 9; i++) aw_hs(0);
        chk("ovf_pulse", 32'(err_pulse), 32'h4000);
        chk("ovf_wr_out", 32'(wr_outstanding), 32'd8);
        do_reset();
        b_hs();
        chk("b_no_wr_pulse", 32'(err_pulse), 32'h1000);

        // Reset mid-burst, then a clean burst
        aw_hs(7);
        w_beat(0); w_beat(0);
        do_reset();
        clr_err = 1; tick(); clr_err = 0;
        chk("midrst_flags", 32'(err_flags), 32'h0);
        chk("midrst_pulse", 32'(err_pulse), 32'h0);
        chk("midrst_wr_out", 32'(wr_outstanding), 32'd0);
        chk("midrst_rd_out", 32'(rd_outstanding), 32'd0);
        aw_hs(1);
        w_beat(0); w_beat(1);
        b_hs();
        chk("post_rst_flags", 32'(err_flags), 32'h0);

        // Randomized traffic, one channel's READY forced low per 200-cycle window
        blk = -1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 200 == 0) blk = ($urandom_range(3) == 0) ? int'($urandom_range(4)) : -1;
            rand_inputs(blk);
            clr_err = ($urandom_range(49) == 0);
            reset = ($urandom_range(499) == 0);
            tick();
        end
        reset = 0; clr_err = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
